// File: rtl/tap_pkg.sv
// Shared constants and types for the .TAP save engine: image framing bytes,
// the latched save request and the serialiser state encoding.
package tap_pkg;

  localparam logic [7:0] TAP_SYNC    = 8'h16;
  localparam logic [7:0] TAP_MARK    = 8'h24;
  localparam int         TAP_HDR_LEN = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_MARK,
    ST_HDR,
    ST_NRD,
    ST_NCAP,
    ST_NEMIT,
    ST_DRD,
    ST_DCAP,
    ST_DEMIT,
    ST_FIN
  } tap_state_t;

  typedef struct packed {
    logic [7:0]  file_type;
    logic [7:0]  autorun;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic [15:0] name_addr;
  } tap_req_t;

endpackage

// File: rtl/tap_writer.sv
// Oric tape-save engine: serialises sync, marker, header, name and a RAM
// range as a .TAP byte stream into the upload buffer.
module tap_writer
  import tap_pkg::*;
#(
  parameter int SYNC_LEN = 4,
  parameter int NAME_MAX = 16
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  file_type,
  input  logic [7:0]  autorun,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  input  logic [15:0] name_addr,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_q,
  output logic [24:0] buf_addr,
  output logic        buf_wr,
  output logic [7:0]  buf_dout,
  input  logic        buf_wait,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [24:0] tap_len
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);
  localparam logic [7:0] NAME_LAST = 8'(NAME_MAX - 1);
  localparam logic [3:0] HDR_LAST  = 4'(TAP_HDR_LEN - 1);

  tap_state_t  state_q, state_d;
  tap_req_t    req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;      // sync index, header index, name byte count
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  byte_q, byte_d;
  logic [24:0] count_q, count_d;

  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_rd_q, ram_rd_d;
  logic [24:0] buf_addr_q, buf_addr_d;
  logic        buf_wr_q, buf_wr_d;
  logic [7:0]  buf_dout_q, buf_dout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [24:0] tap_len_q, tap_len_d;

  logic        wr_req;
  logic [7:0]  wr_byte;
  logic [7:0]  hdr_byte;

  always_comb begin
    hdr_byte = 8'h00;
    case (cnt_q[3:0])
      4'd2:    hdr_byte = req_q.file_type;
      4'd3:    hdr_byte = req_q.autorun;
      4'd4:    hdr_byte = req_q.end_addr[15:8];
      4'd5:    hdr_byte = req_q.end_addr[7:0];
      4'd6:    hdr_byte = req_q.start_addr[15:8];
      4'd7:    hdr_byte = req_q.start_addr[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    byte_d     = byte_q;
    count_d    = count_q;
    ram_addr_d = ram_addr_q;
    ram_rd_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_wr_d   = 1'b0;
    buf_dout_d = buf_dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    tap_len_d  = tap_len_q;
    wr_req     = 1'b0;
    wr_byte    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_d      = '{file_type, autorun, start_addr, end_addr, name_addr};
          busy_d     = 1'b1;
          error_d    = (end_addr < start_addr);
          tap_len_d  = '0;
          count_d    = '0;
          buf_addr_d = '0;
          cnt_d      = '0;
          state_d    = (end_addr < start_addr) ? ST_FIN : ST_SYNC;
        end
      end
      ST_SYNC: begin
        wr_req  = 1'b1;
        wr_byte = TAP_SYNC;
        if (!buf_wait) begin
          if (cnt_q == SYNC_LAST) begin
            cnt_d   = '0;
            state_d = ST_MARK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_MARK: begin
        wr_req  = 1'b1;
        wr_byte = TAP_MARK;
        if (!buf_wait) state_d = ST_HDR;
      end
      ST_HDR: begin
        wr_req  = 1'b1;
        wr_byte = hdr_byte;
        if (!buf_wait) begin
          if (cnt_q[3:0] == HDR_LAST) begin
            cnt_d      = '0;
            ptr_d      = req_q.name_addr;
            ram_addr_d = req_q.name_addr;
            ram_rd_d   = 1'b1;
            state_d    = ST_NRD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_NRD:  state_d = ST_NCAP;
      ST_NCAP: begin
        byte_d  = ram_q;
        state_d = ST_NEMIT;
      end
      ST_NEMIT: begin
        wr_req  = 1'b1;
        wr_byte = byte_q;
        if (!buf_wait) begin
          if (byte_q == 8'h00) begin
            ptr_d      = req_q.start_addr;
            ram_addr_d = req_q.start_addr;
            ram_rd_d   = 1'b1;
            state_d    = ST_DRD;
          end else if (cnt_q == NAME_LAST) begin
            // Name limit reached: emit the terminator without another read.
            byte_d = 8'h00;
          end else begin
            cnt_d      = cnt_q + 8'd1;
            ptr_d      = ptr_q + 16'd1;
            ram_addr_d = ptr_q + 16'd1;
            ram_rd_d   = 1'b1;
            state_d    = ST_NRD;
          end
        end
      end
      ST_DRD:  state_d = ST_DCAP;
      ST_DCAP: begin
        byte_d  = ram_q;
        state_d = ST_DEMIT;
      end
      ST_DEMIT: begin
        wr_req  = 1'b1;
        wr_byte = byte_q;
        if (!buf_wait) begin
          if (ptr_q == req_q.end_addr) begin
            state_d = ST_FIN;
          end else begin
            ptr_d      = ptr_q + 16'd1;
            ram_addr_d = ptr_q + 16'd1;
            ram_rd_d   = 1'b1;
            state_d    = ST_DRD;
          end
        end
      end
      ST_FIN: begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        tap_len_d = count_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_req && !buf_wait) begin
      buf_wr_d   = 1'b1;
      buf_addr_d = count_q;
      buf_dout_d = wr_byte;
      count_d    = count_q + 25'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      byte_q     <= '0;
      count_q    <= '0;
      ram_addr_q <= '0;
      ram_rd_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_wr_q   <= 1'b0;
      buf_dout_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tap_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      byte_q     <= byte_d;
      count_q    <= count_d;
      ram_addr_q <= ram_addr_d;
      ram_rd_q   <= ram_rd_d;
      buf_addr_q <= buf_addr_d;
      buf_wr_q   <= buf_wr_d;
      buf_dout_q <= buf_dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tap_len_q  <= tap_len_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_rd   = ram_rd_q;
  assign buf_addr = buf_addr_q;
  assign buf_wr   = buf_wr_q;
  assign buf_dout = buf_dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign tap_len  = tap_len_q;

endmodule

// File: tb/tb_tap_writer.sv
// Self-checking bench for tap_writer: a RAM model plus a .TAP image model built
// from the file-format rules; every buffer write and RAM read is compared.
module tb_tap_writer;

  localparam int SYNC_LEN = 4;
  localparam int NAME_MAX = 16;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  file_type, autorun;
  logic [15:0] start_addr, end_addr, name_addr;
  logic [15:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic [24:0] buf_addr;
  logic        buf_wr;
  logic [7:0]  buf_dout;
  logic        buf_wait;
  logic        busy, done, error;
  logic [24:0] tap_len;

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  tap_writer #(.SYNC_LEN(SYNC_LEN), .NAME_MAX(NAME_MAX)) dut (
    .clk_48(clk_48), .reset(reset), .start(start),
    .file_type(file_type), .autorun(autorun),
    .start_addr(start_addr), .end_addr(end_addr), .name_addr(name_addr),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
    .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_dout(buf_dout), .buf_wait(buf_wait),
    .busy(busy), .done(done), .error(error), .tap_len(tap_len)
  );

  always #10 clk_48 = ~clk_48;

  // Synchronous RAM: data valid the cycle after the read strobe.
  always @(posedge clk_48) if (ram_rd) ram_q <= mem[ram_addr];

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One save: build the expected image and read sequence, run the DUT and
  // compare each write/read as it appears. sa/sb: write counts at which a
  // 5-cycle buf_wait stall begins (-1 = none).
  task automatic run_save(input logic [15:0] nm, input logic [15:0] st, input logic [15:0] en,
                          input logic [7:0] ft, input logic [7:0] ar,
                          input int sa, input int sb, input string tag);
    logic [7:0]  exp_q[$];
    logic [15:0] rd_q[$];
    logic [15:0] a;
    logic [7:0]  b;
    bit bad, sa_done, sb_done;
    int wr_n, rd_n, first_wr, last_wr, done_cyc, stall_left;

    bad = (en < st);
    if (!bad) begin
      for (int i = 0; i < SYNC_LEN; i++) exp_q.push_back(8'h16);
      exp_q.push_back(8'h24);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(ft);    exp_q.push_back(ar);
      exp_q.push_back(en[15:8]); exp_q.push_back(en[7:0]);
      exp_q.push_back(st[15:8]); exp_q.push_back(st[7:0]);
      exp_q.push_back(8'h00);
      a = nm;
      for (int n = 0; n <= NAME_MAX; n++) begin
        if (n == NAME_MAX) begin exp_q.push_back(8'h00); break; end
        rd_q.push_back(a);
        b = mem[a];
        exp_q.push_back(b);
        if (b == 8'h00) break;
        a = a + 16'd1;
      end
      for (int i = int'(st); i <= int'(en); i++) begin
        rd_q.push_back(16'(i));
        exp_q.push_back(mem[i]);
      end
    end

    @(negedge clk_48);
    start = 1'b1; file_type = ft; autorun = ar;
    start_addr = st; end_addr = en; name_addr = nm;
    @(negedge clk_48);
    start = 1'b0;
    check(32'(busy), 1, {tag, ":busy_rise"});
    check(32'(buf_wr), 0, {tag, ":no_early_wr"});

    wr_n = 0; rd_n = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
    stall_left = 0; sa_done = 0; sb_done = 0;
    for (int cyc = 2; cyc < 3000 && done_cyc < 0; cyc++) begin
      @(negedge clk_48);
      if (buf_wr) begin
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        if (wr_n < exp_q.size()) begin
          check(32'(buf_addr), 32'(wr_n), {tag, ":buf_addr"});
          check(32'(buf_dout), 32'(exp_q[wr_n]), $sformatf("%s:byte%0d", tag, wr_n));
        end else begin
          check(32'(wr_n), 32'(exp_q.size()), {tag, ":extra_write"});
        end
        wr_n++;
      end
      if (ram_rd) begin
        if (rd_n < rd_q.size())
          check(32'(ram_addr), 32'(rd_q[rd_n]), $sformatf("%s:rd%0d", tag, rd_n));
        else
          check(32'(ram_addr), 32'hFFFF_FFFF, {tag, ":extra_read"});
        rd_n++;
      end
      if (done) done_cyc = cyc;
      // Start pulse with junk inputs while busy must be ignored.
      if (cyc == 4) begin
        start = 1'b1; file_type = 8'h5A; autorun = 8'hA5;
        start_addr = 16'h1234; end_addr = 16'h0001; name_addr = 16'h4321;
      end else begin
        start = 1'b0;
      end
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) buf_wait = 1'b0;
      end else if (!sa_done && wr_n == sa) begin
        buf_wait = 1'b1; stall_left = 5; sa_done = 1;
      end else if (!sb_done && wr_n == sb) begin
        buf_wait = 1'b1; stall_left = 5; sb_done = 1;
      end
    end
    buf_wait = 1'b0;
    start = 1'b0;

    check(32'(done_cyc >= 0), 1, {tag, ":done_seen"});
    check(32'(wr_n), 32'(exp_q.size()), {tag, ":write_count"});
    check(32'(rd_n), 32'(rd_q.size()), {tag, ":read_count"});
    check(32'(busy), 0, {tag, ":busy_at_done"});
    check(32'(error), 32'(bad), {tag, ":error"});
    check(32'(tap_len), 32'(exp_q.size()), {tag, ":tap_len"});
    if (bad) check(32'(done_cyc), 2, {tag, ":done_latency"});
    else check(32'(done_cyc), 32'(last_wr + 1), {tag, ":done_after_last_wr"});
    if (!bad && sa != 0 && sb != 0) check(32'(first_wr), 2, {tag, ":first_wr_latency"});
    @(negedge clk_48);
    check(32'(done), 0, {tag, ":done_pulse"});
    check(32'(buf_wr), 0, {tag, ":no_wr_after_done"});
    check(32'(tap_len), 32'(exp_q.size()), {tag, ":tap_len_held"});
  endtask

  initial begin
    int wr_seen;
    logic [15:0] st, nm;
    int len, nlen;

    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    reset = 1'b1; start = 1'b0; buf_wait = 1'b0;
    file_type = 0; autorun = 0; start_addr = 0; end_addr = 0; name_addr = 0;
    repeat (3) @(negedge clk_48);
    check({ram_addr, 15'd0, ram_rd}, 0, "rst:ram");
    check(32'(buf_addr), 0, "rst:buf_addr");
    check({23'd0, buf_wr, buf_dout}, 0, "rst:buf_wr_dout");
    check({29'd0, busy, done, error}, 0, "rst:flags");
    check(32'(tap_len), 0, "rst:tap_len");
    reset = 1'b0;

    // Basic image.
    mem[16'h0500] = 8'h41; mem[16'h0501] = 8'h42; mem[16'h0502] = 8'h00;
    mem[16'h0600] = 8'h11; mem[16'h0601] = 8'h22; mem[16'h0602] = 8'h33;
    run_save(16'h0500, 16'h0600, 16'h0602, 8'h80, 8'h00, -1, -1, "basic");
    check(32'(tap_len), 20, "basic:len20");

    // Empty name.
    mem[16'h0700] = 8'h00;
    run_save(16'h0700, 16'h1000, 16'h1000, 8'h00, 8'hC7, -1, -1, "empty_name");
    check(32'(tap_len), 16, "empty_name:len16");

    // Long name: 20 non-zero bytes, truncated to NAME_MAX.
    for (int i = 0; i < 20; i++) mem[16'h0800 + i] = 8'(8'h41 + i);
    run_save(16'h0800, 16'h2000, 16'h2003, 8'h80, 8'h01, -1, -1, "long_name");
    check(32'(tap_len), 35, "long_name:len35");

    // Top of memory, no wrap.
    mem[16'hFFFF] = 8'h9E;
    run_save(16'h0700, 16'hFFFF, 16'hFFFF, 8'h80, 8'h00, -1, -1, "top_mem");
    check(32'(tap_len), 16, "top_mem:len16");

    // Bad range.
    run_save(16'h0500, 16'h2000, 16'h1FFF, 8'h80, 8'h00, -1, -1, "bad_range");

    // Stalls at header byte 3 and inside the data phase.
    run_save(16'h0500, 16'h0600, 16'h0602, 8'h80, 8'h00, SYNC_LEN + 1 + 3, 18, "stall");

    // Randomized saves.
    for (int t = 0; t < 6; t++) begin
      nm   = 16'h0900 + 16'(t * 64);
      nlen = $urandom_range(0, 18);
      for (int i = 0; i < nlen; i++) mem[nm + 16'(i)] = 8'($urandom_range(1, 255));
      mem[nm + 16'(nlen)] = 8'h00;
      st  = 16'($urandom_range(16'h1000, 16'hF000));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) mem[st + 16'(i)] = 8'($urandom);
      run_save(nm, st, st + 16'(len - 1), 8'($urandom), 8'($urandom),
               $urandom_range(0, 30), $urandom_range(0, 40), $sformatf("rand%0d", t));
    end

    // Reset during the data phase.
    @(negedge clk_48);
    start = 1'b1; file_type = 8'h80; autorun = 8'h00;
    start_addr = 16'h3000; end_addr = 16'h3010; name_addr = 16'h0500;
    @(negedge clk_48);
    start = 1'b0;
    wr_seen = 0;
    for (int cyc = 0; cyc < 200 && wr_seen < 19; cyc++) begin
      @(negedge clk_48);
      if (buf_wr) wr_seen++;
    end
    check(32'(wr_seen), 19, "rst_mid:reached_data");
    reset = 1'b1;
    @(negedge clk_48);
    reset = 1'b0;
    check({ram_addr, 15'd0, ram_rd}, 0, "rst_mid:ram");
    check(32'(buf_addr), 0, "rst_mid:buf_addr");
    check({23'd0, buf_wr, buf_dout}, 0, "rst_mid:buf_wr_dout");
    check({29'd0, busy, done, error}, 0, "rst_mid:flags");
    check(32'(tap_len), 0, "rst_mid:tap_len");
    wr_seen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk_48);
      if (buf_wr || busy || done) wr_seen++;
    end
    check(32'(wr_seen), 0, "rst_mid:quiet");

    run_save(16'h0500, 16'h0600, 16'h0602, 8'h00, 8'hC7, -1, -1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_writer.md
# tap_writer

Tape-save engine for the Oric core: the write-side counterpart of the cassette loader. On a save request it reads a file name and a memory range from main RAM and serialises a standard Oric .TAP image (sync, marker, 9-byte header, null-terminated name, data) as a byte stream into the upload buffer, which the host then retrieves over the ioctl upload path. It sits beside `cassette` in the top level and shares the main RAM read port with the CPU.

## Interface
- `SYNC_LEN`, 4: number of 0x16 sync bytes emitted (1..255).
- `NAME_MAX`, 16: maximum non-zero name bytes read before forcing the terminator.
- `clk_48`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high; clock clk_48.
- `start`  in  1  save request, one-cycle pulse; ignored while `busy`.
- `file_type`  in  8  header type byte (0x00 BASIC, 0x80 machine code).
- `autorun`  in  8  header autorun byte.
- `start_addr`  in  16  first data byte address.
- `end_addr`  in  16  last data byte address, inclusive.
- `name_addr`  in  16  RAM address of the file name.
- `ram_addr`  out  16  RAM read address.
- `ram_rd`  out  1  RAM read strobe.
- `ram_q`  in  8  RAM data; valid the cycle after `ram_rd`.
- `buf_addr`  out  25  upload buffer byte address.
- `buf_wr`  out  1  upload buffer write strobe.
- `buf_dout`  out  8  upload buffer write data.
- `buf_wait`  in  1  buffer stall; no write issued while high.
- `busy`  out  1  save in progress.
- `done`  out  1  one-cycle pulse at completion (also after error).
- `error`  out  1  last request rejected (`end_addr < start_addr`); held until next accepted `start`.
- `tap_len`  out  25  bytes written by last save; valid from `done`, held until next `start`.

## Operation
- `start` in IDLE latches all request inputs, clears `error`, `tap_len`, `buf_addr` counter; sets `busy`.
- Range check first: if `end_addr < start_addr` -> set `error`, pulse `done`, `tap_len`=0, no `buf_wr`, back to IDLE.
- States: IDLE -> SYNC (`SYNC_LEN` × 0x16) -> MARK (0x24) -> HDR (9 bytes: 00, 00, file_type, autorun, end_hi, end_lo, start_hi, start_lo, 00) -> NRD/NCAP/NEMIT (name) -> DRD/DCAP/DEMIT (data) -> FIN -> IDLE.
- Name loop: NRD drives `ram_addr`=name pointer, `ram_rd`=1; NCAP latches `ram_q`; NEMIT writes it. Byte 0x00 is written and ends the name. After `NAME_MAX` non-zero bytes, one forced 0x00 is written without a further read.
- Data loop: same 3-state read/capture/emit, `start_addr` through `end_addr` inclusive. Termination compares pointer to `end_addr` before increment; pointer never wraps (0xFFFF end reads no 0x0000).
- Each write: `buf_wr`=1, `buf_addr`=running count, then count increments. `tap_len` = final count.
- FIN: drop `busy`, pulse `done`.

## Timing
- All outputs registered. Reset values: `ram_addr`=0, `ram_rd`=0, `buf_addr`=0, `buf_wr`=0, `buf_dout`=0, `busy`=0, `done`=0, `error`=0, `tap_len`=0; FSM in IDLE.
- `busy` rises the cycle after `start`; first `buf_wr` two cycles after `start`.
- Generated bytes (SYNC, MARK, HDR): one write per cycle, back-to-back.
- RAM bytes: one write every 3 cycles; `ram_rd` is a single-cycle pulse per byte.
- `buf_wait` high in a write state: `buf_wr`=0, FSM and counters hold, pending byte kept; write issued the first cycle `buf_wait` is low. `buf_wait` does not stall NRD/NCAP/DRD/DCAP (captured byte is held).
- `done` asserts the cycle after the last `buf_wr`; `busy` falls the same cycle.
- `reset` mid-save: next cycle all outputs at reset values, no further writes; partial image discarded.
- `start` during `busy`: no effect.

## Structure
- Package `tap_pkg`: `TAP_SYNC`=8'h16, `TAP_MARK`=8'h24, `TAP_HDR_LEN`=9, state enum `tap_state_t`.
- Single module, no sub-module; header byte selected by a 4-bit index mux.

## Test plan
- Basic: name "AB\0" at 0x0500, range 0x0600-0x0602 = 11 22 33, type 0x80, autorun 0x00 -> stream 16 16 16 16 24 00 00 80 00 06 02 06 00 00 41 42 00 11 22 33 at buf_addr 0..19, `tap_len`=20, one `done`.
- Empty name (0x00 at name_addr), range 0x1000-0x1000 -> single 00 name byte, `tap_len`=16.
- Long name: 20 non-zero bytes -> exactly 16 name bytes + 00, no read beyond name_addr+15.
- Top of memory: start=end=0xFFFF -> one data byte from 0xFFFF, no `ram_rd` to 0x0000, `tap_len`=16 with empty name.
- Bad range: start 0x2000, end 0x1FFF -> no `buf_wr`, `error`=1, `done` pulse, `tap_len`=0.
- Stall/reset: `buf_wait` high 5 cycles at header byte 3 and during a DEMIT -> identical stream, no drop/duplicate; `reset` during data -> all outputs 0 next cycle, no further `buf_wr`.
